// File: rtl/row_scan_pkg.sv
// Shared types and constants for the row scan sequencer and its next-row finder.
package row_scan_pkg;

  localparam int NUM_ROWS  = 16;
  localparam int SEL_W     = 4;
  localparam int BLANK_MIN = 2;
  localparam int BLANK_MAX = 255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic logic [SEL_W-1:0] lowest_set(input logic [NUM_ROWS-1:0] m);
    logic [SEL_W-1:0] r;
    r = '0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (m[i]) r = SEL_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/row_scan_sequencer_row_next_finder.sv
// Combinational search for the next enabled row strictly above cur, wrapping to the lowest enabled row.
module row_next_finder
  import row_scan_pkg::*;
(
  input  logic [SEL_W-1:0]    cur,
  input  logic [NUM_ROWS-1:0] mask,
  output logic [SEL_W-1:0]    next,
  output logic                wrapped,
  output logic                none
);

  logic [NUM_ROWS-1:0] above;

  always_comb begin
    above   = mask & (({NUM_ROWS{1'b1}} << cur) << 1);
    none    = (mask == '0);
    wrapped = (above == '0);
    next    = wrapped ? lowest_set(mask) : lowest_set(above);
  end

endmodule

// File: rtl/row_scan_sequencer.sv
// Row scan controller for a 4-to-16 decoder with active-low enable: masked rows, programmable dwell,
// blanking around every select change. Optional frame counter output under ROW_SCAN_FRAME_CNT_EN.
module row_scan_sequencer
  import row_scan_pkg::*;
#(
  parameter int DWELL_W      = 16,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stop,
  input  logic                single,
  input  logic [DWELL_W-1:0]  dwell,
  input  logic [NUM_ROWS-1:0] row_mask,
  output logic [SEL_W-1:0]    sel,
  output logic                en_n,
  output logic                busy,
  output logic                frame_done
`ifdef ROW_SCAN_FRAME_CNT_EN
  ,
  output logic [15:0]         frame_cnt
`endif
);

  if (BLANK_CYCLES < BLANK_MIN || BLANK_CYCLES > BLANK_MAX) begin : g_bad_blank
    $error("row_scan_sequencer: BLANK_CYCLES must be in 2..255");
  end

  // One counter serves both the blank and dwell phases, so it must hold either range.
  localparam int CNT_W = (DWELL_W > 8) ? DWELL_W : 8;
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] pend_q, pend_d;
  logic [SEL_W-1:0] sel_d;
  logic             en_n_d, busy_d, fd_d;
  logic [SEL_W-1:0] nxt;
  logic             wrapped, none;
  logic [CNT_W-1:0] dwell_load;

  row_next_finder u_finder (
    .cur     (sel),
    .mask    (row_mask),
    .next    (nxt),
    .wrapped (wrapped),
    .none    (none)
  );

  assign dwell_load = (dwell == '0) ? '0 : CNT_W'(dwell - 1'b1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    sel_d   = sel;
    fd_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && row_mask != '0) begin
          state_d = BLANK;
          sel_d   = lowest_set(row_mask);
          pend_d  = lowest_set(row_mask);
          cnt_d   = BLANK_LOAD;
        end
      end
      BLANK: begin
        // Select moves only after one full blank cycle with the old row.
        if (cnt_q == BLANK_LOAD) sel_d = pend_q;
        if (cnt_q == '0) begin
          state_d = DRIVE;
          cnt_d   = dwell_load;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DRIVE: begin
        if (cnt_q == '0) begin
          fd_d    = wrapped | none;
          pend_d  = nxt;
          cnt_d   = BLANK_LOAD;
          state_d = (fd_d && (single || none)) ? IDLE : BLANK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (stop) begin
      state_d = IDLE;
      sel_d   = sel;
      pend_d  = pend_q;
      fd_d    = 1'b0;
    end
    en_n_d = (state_d != DRIVE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pend_q     <= '0;
      sel        <= '0;
      en_n       <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      sel        <= sel_d;
      en_n       <= en_n_d;
      busy       <= busy_d;
      frame_done <= fd_d;
    end
  end

`ifdef ROW_SCAN_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)    frame_cnt <= '0;
    else if (fd_d) frame_cnt <= frame_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_row_scan_sequencer.sv
// Directed bench for row_scan_sequencer: vector table for frame timing, hand sequences for corner cases.
module tb_row_scan_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop, single;
  logic [15:0] dwell, row_mask;
  logic [3:0]  sel;
  logic        en_n, busy, frame_done;
`ifdef ROW_SCAN_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  row_scan_sequencer #(.DWELL_W(16), .BLANK_CYCLES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .single     (single),
    .dwell      (dwell),
    .row_mask   (row_mask),
    .sel        (sel),
    .en_n       (en_n),
    .busy       (busy),
    .frame_done (frame_done)
`ifdef ROW_SCAN_FRAME_CNT_EN
    ,
    .frame_cnt  (frame_cnt)
`endif
  );

  typedef struct {
    logic        start;
    logic        stop;
    logic [15:0] mask;
    logic [3:0]  sel;
    logic        en_n;
    logic        busy;
    logic        fd;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    start  = 1'b0;
    stop   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [3:0] prev_sel, exp_row;
    logic       prev_en, found;
    int         last_fd, nfd, n;

    // Frame timing with dwell=3, mask=0x0005, single; then rejected starts.
    vt[0]  = '{1'b1, 1'b0, 16'h0005, 4'd0, 1'b1, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 1'b0, 16'h0005, 4'd0, 1'b1, 1'b1, 1'b0};
    vt[2]  = '{1'b0, 1'b0, 16'h0005, 4'd0, 1'b1, 1'b1, 1'b0};
    vt[3]  = '{1'b0, 1'b0, 16'h0005, 4'd0, 1'b0, 1'b1, 1'b0};
    vt[4]  = '{1'b1, 1'b0, 16'h0005, 4'd0, 1'b0, 1'b1, 1'b0};
    vt[5]  = '{1'b0, 1'b0, 16'h0005, 4'd0, 1'b0, 1'b1, 1'b0};
    vt[6]  = '{1'b0, 1'b0, 16'h0005, 4'd0, 1'b1, 1'b1, 1'b0};
    vt[7]  = '{1'b0, 1'b0, 16'h0005, 4'd2, 1'b1, 1'b1, 1'b0};
    vt[8]  = '{1'b0, 1'b0, 16'h0005, 4'd2, 1'b0, 1'b1, 1'b0};
    vt[9]  = '{1'b0, 1'b0, 16'h0005, 4'd2, 1'b0, 1'b1, 1'b0};
    vt[10] = '{1'b0, 1'b0, 16'h0005, 4'd2, 1'b0, 1'b1, 1'b0};
    vt[11] = '{1'b0, 1'b0, 16'h0005, 4'd2, 1'b1, 1'b0, 1'b1};
    vt[12] = '{1'b1, 1'b0, 16'h0000, 4'd2, 1'b1, 1'b0, 1'b0};
    vt[13] = '{1'b1, 1'b1, 16'h0005, 4'd2, 1'b1, 1'b0, 1'b0};
    vt[14] = '{1'b0, 1'b0, 16'h0005, 4'd2, 1'b1, 1'b0, 1'b0};
    vt[15] = '{1'b0, 1'b0, 16'h0005, 4'd2, 1'b1, 1'b0, 1'b0};

    single   = 1'b1;
    dwell    = 16'd3;
    row_mask = 16'h0005;
    do_reset();
    chk("reset_state", {28'd0, sel, en_n, busy, frame_done}, {28'd0, 4'd0, 1'b1, 1'b0, 1'b0});
`ifdef ROW_SCAN_FRAME_CNT_EN
    chk("reset_frame_cnt", {16'd0, frame_cnt}, 32'd0);
`endif
    for (int i = 0; i < 16; i++) begin
      start    = vt[i].start;
      stop     = vt[i].stop;
      row_mask = vt[i].mask;
      chk($sformatf("vec%0d", i), {sel, en_n, busy, frame_done},
          {vt[i].sel, vt[i].en_n, vt[i].busy, vt[i].fd});
      @(negedge clk);
    end

    // Free run over all 16 rows with dwell=1: row order, blanking around sel changes, frame period.
    do_reset();
    row_mask = 16'hFFFF;
    dwell    = 16'd1;
    single   = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    prev_sel = sel;
    prev_en  = en_n;
    exp_row  = 4'd0;
    last_fd  = -1;
    nfd      = 0;
    for (int c = 1; c <= 160; c++) begin
      if (sel !== prev_sel) chk("glitch", {30'd0, prev_en, en_n}, 32'd3);
      if (!en_n && prev_en) begin
        chk("row_seq", {28'd0, sel}, {28'd0, exp_row});
        exp_row = exp_row + 4'd1;
      end
      if (frame_done) begin
        if (last_fd >= 0) chk("fd_period", c - last_fd, 48);
        last_fd = c;
        nfd++;
      end
      prev_sel = sel;
      prev_en  = en_n;
      @(negedge clk);
    end
    chk("fd_count", nfd, 3);

    // Stop while row 7 is driven.
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    do_reset();
    dwell = 16'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (sel == 4'd7 && !en_n) found = 1'b1;
      else @(negedge clk);
    end
    chk("wait_row7", {31'd0, found}, 32'd1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_row7", {sel, en_n, busy, frame_done}, {4'd7, 1'b1, 1'b0, 1'b0});
    @(negedge clk);
    chk("stop_quiet", {sel, en_n, busy, frame_done}, {4'd7, 1'b1, 1'b0, 1'b0});

    // Mask cleared while row 3 is driven: dwell completes, then frame end and IDLE.
    do_reset();
    row_mask = 16'hFFFF;
    dwell    = 16'd5;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (sel == 4'd3 && !en_n) found = 1'b1;
      else @(negedge clk);
    end
    chk("wait_row3", {31'd0, found}, 32'd1);
    row_mask = 16'h0000;
    n = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (!en_n) n++;
    end
    chk("mask_clr_dwell", n, 4);
    @(negedge clk);
    chk("mask_clr_end", {sel, en_n, busy, frame_done}, {4'd3, 1'b1, 1'b0, 1'b1});
    @(negedge clk);
    chk("mask_clr_idle", {30'd0, busy, frame_done}, 32'd0);

    // Reset asserted during DRIVE releases the decoder on the next edge.
    do_reset();
    row_mask = 16'hFFFF;
    dwell    = 16'd8;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      if (!en_n) found = 1'b1;
      else @(negedge clk);
    end
    chk("wait_drive", {31'd0, found}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset_mid_drive", {sel, en_n, busy, frame_done}, {4'd0, 1'b1, 1'b0, 1'b0});
    rst_n = 1'b1;

`ifdef ROW_SCAN_FRAME_CNT_EN
    do_reset();
    row_mask = 16'h0001;
    dwell    = 16'd1;
    single   = 1'b1;
    for (int f = 0; f < 3; f++) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
    end
    chk("frame_cnt", {16'd0, frame_cnt}, 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
